usb_data_arbiter: RTL and testbench
===================================

USB_DATA_ARBITER -- requirements
Module: usb_data_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning words per source buffer (power of 2, 4..64).
REQ-002 SHALL have parameter BURST, default 4, meaning the maximum words drained per grant (1..DEPTH).
REQ-003 SHALL have these ports, one per line:
- Clk  input  1  sole clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- AcqData  input  16  Microroc acquisition word (source 0)
- AcqData_en  input  1  one-cycle write strobe for AcqData
- AdcData  input  16  ADC sum word (source 1)
- AdcData_en  input  1  write strobe for AdcData
- SCTestData  input  16  S-curve test word (source 2)
- SCTestData_en  input  1  write strobe for SCTestData
- ArbEnable  input  1  1 = draining allowed
- UsbDataFifoFull  input  1  external USB FIFO full
- ClearStatus  input  1  one-cycle pulse that clears the overflow flags
- OutUsbExtFifoData  output  16  word to the USB FIFO
- OutUsbExtFifoData_en  output  1  write strobe to the USB FIFO
- SourceOverflow  output  3  sticky per-source drop flag
- Grant  output  2  current grant (0/1/2; 3 = none)
- ArbIdle  output  1  1 = all buffers empty and state IDLE

Function
REQ-004 SHALL keep one independent DEPTH-word FIFO per source.
REQ-005 SHALL write on a strobe only when that FIFO holds fewer than DEPTH words.
REQ-006 SHALL drop a strobed word when its FIFO holds DEPTH words, even if the same cycle pops; the drop SHALL set that source's SourceOverflow bit on the next edge.
REQ-007 SHALL allow a write and a pop on one FIFO in the same cycle when not full; the count is then unchanged.
REQ-008 SHALL implement the FSM IDLE and BURST.
REQ-009 IDLE: when ArbEnable=1, UsbDataFifoFull=0 and any FIFO is non-empty, SHALL select the non-empty source first in round-robin order, pop its head that cycle, load Grant, set the burst count to 1, and go to BURST.
REQ-010 Round-robin order SHALL start at the source after the last granted one (mod 3); after reset it SHALL start at source 0.
REQ-011 BURST: when the granted FIFO is non-empty, the burst count is less than BURST, UsbDataFifoFull=0 and ArbEnable=1, SHALL pop one word and increment the count.
REQ-012 BURST: when the granted FIFO is empty or the count equals BURST, SHALL go to IDLE without popping that cycle and set Grant to 3.
REQ-013 BURST: when UsbDataFifoFull=1 or ArbEnable=0, SHALL hold state, Grant and count with no pop.
REQ-014 A popped word SHALL appear registered on OutUsbExtFifoData with OutUsbExtFifoData_en=1 for exactly the cycle after the pop; there SHALL be no other output strobes.
REQ-015 Latency SHALL be 2 cycles: a strobe in cycle N into an empty, idle block yields OutUsbExtFifoData_en=1 in cycle N+2.
REQ-016 Words from one source SHALL leave in write order; there SHALL be no loss except per REQ-006.
REQ-017 ClearStatus SHALL clear SourceOverflow; a drop in the same cycle SHALL take priority (the bit stays 1).
REQ-018 ArbIdle SHALL be 1 exactly when state=IDLE and all FIFO counts are 0 (registered).

Reset
REQ-019 With reset=1 at a rising edge, SHALL empty all FIFOs, set state IDLE, Grant=3, round-robin pointer to source 0, burst count 0, SourceOverflow=0, OutUsbExtFifoData=0, OutUsbExtFifoData_en=0, ArbIdle=1.
REQ-020 A reset mid-BURST SHALL discard all buffered words; strobes in the reset cycle SHALL be ignored.

Configuration
REQ-021 With macro USB_ARB_OVERFLOW_COUNT_EN defined, SHALL add outputs AcqDropCount, AdcDropCount and SCTestDropCount (16 bits each) that count dropped words, saturate at 16'hFFFF, and clear on reset or ClearStatus (a same-cycle drop then loads 1).
REQ-022 Without USB_ARB_OVERFLOW_COUNT_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-023 Reset, then AcqData=16'h1234 strobed in cycle 0 -> OutUsbExtFifoData=16'h1234 with _en=1 in cycle 2 only; ArbIdle returns to 1.
REQ-024 Six Acq words and six ADC words preloaded with ArbEnable=0, then ArbEnable=1 -> output order A0-A3, ADC0-ADC3, A4-A5, ADC4-ADC5; one idle cycle between bursts.
REQ-025 Nine AdcData strobes with ArbEnable=0 -> 8 buffered; SourceOverflow=3'b010; AdcDropCount=1 when the macro is defined.
REQ-026 UsbDataFifoFull=1 for 5 cycles mid-burst -> no output strobes; Grant held; the burst resumes with no loss or duplication.
REQ-027 reset asserted mid-burst with 3 words buffered -> next cycle _en=0, Grant=3, ArbIdle=1; no buffered words are output afterward.
REQ-028 All three sources are strobed every cycle for 100 cycles with the USB FIFO never full -> per-source order preserved, grants rotate 0,1,2, and each source's output words plus drops equal its strobes.

Source files
------------

// File: rtl/usb_data_arbiter.sv
// Three-source USB data arbiter: per-source FIFOs drained round-robin in bursts to the USB FIFO.
// Optional per-source drop counters are built when USB_ARB_OVERFLOW_COUNT_EN is defined.
module usb_data_arbiter #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [15:0] AcqData,
    input  logic        AcqData_en,
    input  logic [15:0] AdcData,
    input  logic        AdcData_en,
    input  logic [15:0] SCTestData,
    input  logic        SCTestData_en,
    input  logic        ArbEnable,
    input  logic        UsbDataFifoFull,
    input  logic        ClearStatus,
    output logic [15:0] OutUsbExtFifoData,
    output logic        OutUsbExtFifoData_en,
    output logic [2:0]  SourceOverflow,
    output logic [1:0]  Grant,
`ifdef USB_ARB_OVERFLOW_COUNT_EN
    output logic [15:0] AcqDropCount,
    output logic [15:0] AdcDropCount,
    output logic [15:0] SCTestDropCount,
`endif
    output logic        ArbIdle
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(BURST + 1);
    localparam logic [1:0] NoGrant = 2'd3;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e        stateQ, stateD;
    logic [1:0]    grantQ, grantD;
    logic [1:0]    rrQ, rrD;
    logic [BW-1:0] burstCntQ, burstCntD;

    logic [15:0]   srcData [3];
    logic [2:0]    srcEn;
    logic [15:0]   mem [3][DEPTH];
    logic [AW-1:0] wrPtrQ [3];
    logic [AW-1:0] rdPtrQ [3];
    logic [CW-1:0] countQ [3];
    logic [CW-1:0] countD [3];
    logic [3:0]    fifoEmpty;
    logic [2:0]    fifoFull, wrEn, drop, popVec;
    logic          nextAllEmpty;

    logic [2:0]    cand;
    logic [1:0]    rrSel;
    logic          anyValid, canStart, stall;
    logic          popValid;
    logic [1:0]    popSrc;
    logic [15:0]   headData;

    logic [15:0]   outDataQ;
    logic          outEnQ;
    logic [2:0]    ovfQ;
    logic          arbIdleQ;

    assign srcData[0] = AcqData;
    assign srcData[1] = AdcData;
    assign srcData[2] = SCTestData;
    assign srcEn      = {SCTestData_en, AdcData_en, AcqData_en};

    // A full FIFO drops the strobed word even when it pops in the same cycle.
    always_comb begin
        fifoEmpty = 4'b1000;
        fifoFull  = '0;
        wrEn      = '0;
        drop      = '0;
        for (int i = 0; i < 3; i++) begin
            fifoEmpty[i] = (countQ[i] == '0);
            fifoFull[i]  = (countQ[i] == CW'(DEPTH));
            wrEn[i]      = srcEn[i] && !fifoFull[i];
            drop[i]      = srcEn[i] && fifoFull[i];
        end
    end

    always_comb begin
        popVec       = '0;
        nextAllEmpty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            popVec[i] = popValid && (popSrc == 2'(i));
            countD[i] = countQ[i] + CW'(wrEn[i]) - CW'(popVec[i]);
            if (countD[i] != '0) begin
                nextAllEmpty = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                wrPtrQ[i] <= '0;
                rdPtrQ[i] <= '0;
                countQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wrEn[i]) begin
                    wrPtrQ[i] <= wrPtrQ[i] + AW'(1);
                end
                if (popVec[i]) begin
                    rdPtrQ[i] <= rdPtrQ[i] + AW'(1);
                end
                countQ[i] <= countD[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wrEn[i]) begin
                mem[i][wrPtrQ[i]] <= srcData[i];
            end
        end
    end

    always_comb begin
        case (popSrc)
            2'd0:    headData = mem[0][rdPtrQ[0]];
            2'd1:    headData = mem[1][rdPtrQ[1]];
            2'd2:    headData = mem[2][rdPtrQ[2]];
            default: headData = '0;
        endcase
    end

    // First non-empty source scanning upward from rrQ, wrapping modulo 3.
    always_comb begin
        rrSel    = rrQ;
        anyValid = 1'b0;
        cand     = '0;
        for (int k = 0; k < 3; k++) begin
            cand = 3'(rrQ) + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!anyValid && !fifoEmpty[cand[1:0]]) begin
                anyValid = 1'b1;
                rrSel    = cand[1:0];
            end
        end
    end

    assign stall    = !ArbEnable || UsbDataFifoFull;
    assign canStart = !stall && anyValid;

    always_ff @(posedge Clk) begin
        if (reset) begin
            stateQ    <= StIdle;
            grantQ    <= NoGrant;
            rrQ       <= 2'd0;
            burstCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            grantQ    <= grantD;
            rrQ       <= rrD;
            burstCntQ <= burstCntD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        grantD    = grantQ;
        rrD       = rrQ;
        burstCntD = burstCntQ;
        case (stateQ)
            StIdle: begin
                if (canStart) begin
                    stateD    = StBurst;
                    grantD    = rrSel;
                    rrD       = (rrSel == 2'd2) ? 2'd0 : rrSel + 2'd1;
                    burstCntD = BW'(1);
                end
            end
            StBurst: begin
                // A stalled burst holds even if it would otherwise end.
                if (!stall) begin
                    if (fifoEmpty[grantQ] || burstCntQ == BW'(BURST)) begin
                        stateD    = StIdle;
                        grantD    = NoGrant;
                        burstCntD = '0;
                    end else begin
                        burstCntD = burstCntQ + BW'(1);
                    end
                end
            end
            default: begin
                stateD    = StIdle;
                grantD    = NoGrant;
                burstCntD = '0;
            end
        endcase
    end

    always_comb begin
        popValid = 1'b0;
        popSrc   = grantQ;
        case (stateQ)
            StIdle: begin
                if (canStart) begin
                    popValid = 1'b1;
                    popSrc   = rrSel;
                end
            end
            StBurst: begin
                popValid = !stall && !fifoEmpty[grantQ] && (burstCntQ < BW'(BURST));
            end
            default: popValid = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            outDataQ <= '0;
            outEnQ   <= 1'b0;
            ovfQ     <= '0;
            arbIdleQ <= 1'b1;
        end else begin
            outEnQ <= popValid;
            if (popValid) begin
                outDataQ <= headData;
            end
            for (int i = 0; i < 3; i++) begin
                if (drop[i]) begin
                    ovfQ[i] <= 1'b1;
                end else if (ClearStatus) begin
                    ovfQ[i] <= 1'b0;
                end
            end
            arbIdleQ <= (stateD == StIdle) && nextAllEmpty;
        end
    end

    assign OutUsbExtFifoData    = outDataQ;
    assign OutUsbExtFifoData_en = outEnQ;
    assign SourceOverflow       = ovfQ;
    assign Grant                = grantQ;
    assign ArbIdle              = arbIdleQ;

`ifdef USB_ARB_OVERFLOW_COUNT_EN
    logic [15:0] dropCntQ [3];

    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                dropCntQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ClearStatus) begin
                    dropCntQ[i] <= drop[i] ? 16'd1 : 16'd0;
                end else if (drop[i] && dropCntQ[i] != 16'hFFFF) begin
                    dropCntQ[i] <= dropCntQ[i] + 16'd1;
                end
            end
        end
    end

    assign AcqDropCount    = dropCntQ[0];
    assign AdcDropCount    = dropCntQ[1];
    assign SCTestDropCount = dropCntQ[2];
`endif

endmodule

// File: tb/tb_usb_data_arbiter.sv
// Self-checking bench for usb_data_arbiter: vector table plus directed multi-cycle sequences.
// Drop-counter checks are compiled in when USB_ARB_OVERFLOW_COUNT_EN is defined.
module tb_usb_data_arbiter;

    localparam int DEPTH = 8;
    localparam int BURST = 4;

    logic        Clk = 1'b0;
    logic        reset;
    logic [15:0] AcqData, AdcData, SCTestData;
    logic        AcqData_en, AdcData_en, SCTestData_en;
    logic        ArbEnable, UsbDataFifoFull, ClearStatus;
    logic [15:0] outData;
    logic        outEn;
    logic [2:0]  ovf;
    logic [1:0]  grant;
    logic        arbIdle;
`ifdef USB_ARB_OVERFLOW_COUNT_EN
    logic [15:0] acqDrop, adcDrop, scDrop;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    usb_data_arbiter #(.DEPTH(DEPTH), .BURST(BURST)) dut (
        .Clk                  (Clk),
        .reset                (reset),
        .AcqData              (AcqData),
        .AcqData_en           (AcqData_en),
        .AdcData              (AdcData),
        .AdcData_en           (AdcData_en),
        .SCTestData           (SCTestData),
        .SCTestData_en        (SCTestData_en),
        .ArbEnable            (ArbEnable),
        .UsbDataFifoFull      (UsbDataFifoFull),
        .ClearStatus          (ClearStatus),
        .OutUsbExtFifoData    (outData),
        .OutUsbExtFifoData_en (outEn),
        .SourceOverflow       (ovf),
        .Grant                (grant),
`ifdef USB_ARB_OVERFLOW_COUNT_EN
        .AcqDropCount         (acqDrop),
        .AdcDropCount         (adcDrop),
        .SCTestDropCount      (scDrop),
`endif
        .ArbIdle              (arbIdle)
    );

    typedef struct {
        logic        acqEn;
        logic [15:0] acq;
        logic        adcEn;
        logic [15:0] adc;
        logic        arbEn;
        logic        clr;
        logic        expEn;
        logic [15:0] expData;
        logic [1:0]  expGrant;
        logic        expIdle;
        logic [2:0]  expOvf;
        logic [15:0] expAdcDrop;
    } vec_t;

    vec_t vecs[$];

    typedef logic [15:0] wq_t[$];
    wq_t  mq [3];
    int   outs [3];
    int   drops [3];
    logic [1:0] prevGrant;
    logic [1:0] nextGrant;

    function automatic vec_t mkVec(input logic acqEn, input logic [15:0] acq, input logic adcEn,
                                   input logic [15:0] adc, input logic arbEn, input logic clr,
                                   input logic expEn, input logic [15:0] expData,
                                   input logic [1:0] expGrant, input logic expIdle,
                                   input logic [2:0] expOvf, input logic [15:0] expAdcDrop);
        vec_t v;
        v.acqEn = acqEn; v.acq = acq; v.adcEn = adcEn; v.adc = adc;
        v.arbEn = arbEn; v.clr = clr; v.expEn = expEn; v.expData = expData;
        v.expGrant = expGrant; v.expIdle = expIdle; v.expOvf = expOvf;
        v.expAdcDrop = expAdcDrop;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearInputs();
        AcqData = '0; AdcData = '0; SCTestData = '0;
        AcqData_en = 1'b0; AdcData_en = 1'b0; SCTestData_en = 1'b0;
        ArbEnable = 1'b0; UsbDataFifoFull = 1'b0; ClearStatus = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic stressObserve(input bit strobing, input int c);
        bit wasFull [3];
        logic [15:0] exp;
        int src;
        for (int i = 0; i < 3; i++) wasFull[i] = (mq[i].size() >= DEPTH);
        tick();
        if (outEn) begin
            src = int'(outData[15:14]);
            if (src == 3 || mq[src].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stress unexpected word actual=%h required=none", outData);
            end else begin
                exp = mq[src].pop_front();
                check("stress order", 32'(outData), 32'(exp));
                outs[src]++;
            end
        end
        if (strobing) begin
            for (int i = 0; i < 3; i++) begin
                if (wasFull[i]) drops[i]++;
                else mq[i].push_back({2'(i), 14'(c)});
            end
            if (grant != 2'd3 && prevGrant == 2'd3) begin
                check("stress rotation", 32'(grant), 32'(nextGrant));
                nextGrant = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
            end
        end
        prevGrant = grant;
    endtask

    initial begin
        vec_t v;
        logic [15:0] got[$];
        int ks[$];
        logic [15:0] ds[$];
        int expK[12];
        logic [15:0] expD[12];
        int cnt;
        bit done;

        // Table: single-word latency, ADC overflow with clear priority, then an 8-word drain.
        vecs.push_back(mkVec(1, 16'h1234, 0, 0, 1, 0, 0, 0, 3, 0, 3'b000, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 1, 16'h1234, 0, 0, 3'b000, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 0, 0, 3, 1, 3'b000, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 3'b000, 0));
        for (int k = 0; k < 9; k++)
            vecs.push_back(mkVec(0, 0, 1, 16'(16'hA000 + k), 0, 0, 0, 0, 3, 0,
                                 (k == 8) ? 3'b010 : 3'b000, (k == 8) ? 16'd1 : 16'd0));
        vecs.push_back(mkVec(0, 0, 1, 16'hA0FF, 0, 1, 0, 0, 3, 0, 3'b010, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 3'b000, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 1, 16'(16'hA000 + k), 1, 0, 3'b000, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 3'b000, 0));
        for (int k = 4; k < 8; k++)
            vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 1, 16'(16'hA000 + k), 1, 0, 3'b000, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 0, 0, 3, 1, 3'b000, 0));

        doReset();
        check("reset en", 32'(outEn), 32'(0));
        check("reset data", 32'(outData), 32'(0));
        check("reset grant", 32'(grant), 32'(3));
        check("reset idle", 32'(arbIdle), 32'(1));
        check("reset ovf", 32'(ovf), 32'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            AcqData = v.acq; AcqData_en = v.acqEn;
            AdcData = v.adc; AdcData_en = v.adcEn;
            ArbEnable = v.arbEn; ClearStatus = v.clr;
            tick();
            check($sformatf("vec%0d en", i), 32'(outEn), 32'(v.expEn));
            if (v.expEn) check($sformatf("vec%0d data", i), 32'(outData), 32'(v.expData));
            check($sformatf("vec%0d grant", i), 32'(grant), 32'(v.expGrant));
            check($sformatf("vec%0d idle", i), 32'(arbIdle), 32'(v.expIdle));
            check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(v.expOvf));
`ifdef USB_ARB_OVERFLOW_COUNT_EN
            check($sformatf("vec%0d adcdrop", i), 32'(adcDrop), 32'(v.expAdcDrop));
`endif
        end

        // Interleaved bursts: 6 Acq + 6 ADC preloaded, then drained.
        doReset();
        for (int i = 0; i < 6; i++) begin
            AcqData = 16'(16'h1000 + i); AcqData_en = 1'b1;
            AdcData = 16'(16'h2000 + i); AdcData_en = 1'b1;
            tick();
        end
        clearInputs();
        ArbEnable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (outEn) begin
                ks.push_back(k);
                ds.push_back(outData);
            end
        end
        expK = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12, 14, 15};
        expD = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h2000, 16'h2001, 16'h2002,
                 16'h2003, 16'h1004, 16'h1005, 16'h2004, 16'h2005};
        check("order count", 32'(ks.size()), 32'(12));
        for (int i = 0; i < 12 && i < ks.size(); i++) begin
            check($sformatf("order cycle%0d", i), 32'(ks[i]), 32'(expK[i]));
            check($sformatf("order word%0d", i), 32'(ds[i]), 32'(expD[i]));
        end
        check("order idle", 32'(arbIdle), 32'(1));

        // Stall mid-burst with the USB FIFO full.
        doReset();
        for (int i = 0; i < 6; i++) begin
            AcqData = 16'(16'h3000 + i); AcqData_en = 1'b1;
            tick();
        end
        clearInputs();
        ArbEnable = 1'b1;
        tick();
        check("stall w0", 32'(outData), 32'(16'h3000));
        tick();
        check("stall w1", 32'(outData), 32'(16'h3001));
        UsbDataFifoFull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("stall en%0d", k), 32'(outEn), 32'(0));
            check($sformatf("stall grant%0d", k), 32'(grant), 32'(0));
        end
        UsbDataFifoFull = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (outEn) got.push_back(outData);
        end
        check("stall count", 32'(got.size()), 32'(4));
        for (int i = 0; i < 4 && i < got.size(); i++)
            check($sformatf("stall rest%0d", i), 32'(got[i]), 32'(16'h3002 + i));

        // Reset mid-burst with three words still buffered, strobe in the reset cycle.
        doReset();
        for (int i = 0; i < 5; i++) begin
            AcqData = 16'(16'h4000 + i); AcqData_en = 1'b1;
            tick();
        end
        clearInputs();
        ArbEnable = 1'b1;
        tick();
        tick();
        check("midrst pre grant", 32'(grant), 32'(0));
        reset = 1'b1;
        AcqData = 16'h4FFF; AcqData_en = 1'b1;
        tick();
        reset = 1'b0;
        AcqData_en = 1'b0;
        check("midrst en", 32'(outEn), 32'(0));
        check("midrst grant", 32'(grant), 32'(3));
        check("midrst idle", 32'(arbIdle), 32'(1));
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (outEn) cnt++;
        end
        check("midrst no output", 32'(cnt), 32'(0));
        check("midrst idle after", 32'(arbIdle), 32'(1));

        // All three sources strobed every cycle, checked against a queue scoreboard.
        doReset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = {};
            outs[i] = 0;
            drops[i] = 0;
        end
        prevGrant = 2'd3;
        nextGrant = 2'd0;
        ArbEnable = 1'b1;
        for (int c = 0; c < 100; c++) begin
            AcqData = {2'd0, 14'(c)};
            AdcData = {2'd1, 14'(c)};
            SCTestData = {2'd2, 14'(c)};
            AcqData_en = 1'b1; AdcData_en = 1'b1; SCTestData_en = 1'b1;
            stressObserve(1'b1, c);
        end
        AcqData_en = 1'b0; AdcData_en = 1'b0; SCTestData_en = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            stressObserve(1'b0, 0);
            if (arbIdle) done = 1'b1;
        end
        check("stress drained", 32'(arbIdle), 32'(1));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stress left%0d", i), 32'(mq[i].size()), 32'(0));
            check($sformatf("stress total%0d", i), 32'(outs[i] + drops[i]), 32'(100));
            check($sformatf("stress ovf%0d", i), 32'(ovf[i]), 32'(drops[i] > 0));
        end
`ifdef USB_ARB_OVERFLOW_COUNT_EN
        check("stress acqdrop", 32'(acqDrop), 32'(drops[0]));
        check("stress adcdrop", 32'(adcDrop), 32'(drops[1]));
        check("stress scdrop", 32'(scDrop), 32'(drops[2]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
